// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: registered decode bundle, operand forwarding selects,
// load-use bubble insertion and flush on PC redirect.
module decode_stage #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inValid,
  input  logic [31:0]        inInstr,
  input  logic [ADDR_W-1:0]  inPc,
  output logic               inReady,
  input  logic               stallIn,
  input  logic               flush,
  output logic               outValid,
  output logic [STATE_W-1:0] state,
  output logic [2:0]         func3,
  output logic               func7b5,
  output logic [DATA_W-1:0]  imm,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic [4:0]         rd,
  output logic [ADDR_W-1:0]  pcOut,
  output logic [1:0]         forwardA,
  output logic [1:0]         forwardB,
  output logic               illegal
);

  typedef enum logic [3:0] {
    StIdle            = 4'd0,
    StRegWrite        = 4'd1,
    StMemReadRegWrite = 4'd2,
    StMemWrite        = 4'd3,
    StPcSelectWrite   = 4'd4,
    StPcWrite         = 4'd5,
    StLuiRegWrite     = 4'd6
  } state_e;

  typedef struct packed {
    logic       writes;
    logic [4:0] rd;
    logic       is_load;
  } hist_t;

  typedef struct packed {
    logic               valid;
    logic [STATE_W-1:0] state;
    logic [2:0]         func3;
    logic               func7b5;
    logic [DATA_W-1:0]  imm;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [4:0]         rd;
    logic [ADDR_W-1:0]  pc;
    logic [1:0]         fwd_a;
    logic [1:0]         fwd_b;
    logic               illegal;
  } out_t;

  out_t  out_q, out_d, dec_bundle;
  hist_t hist1_q, hist1_d, hist2_q, hist2_d;

  state_e      dec_state;
  logic [31:0] dec_imm;
  logic        dec_legal;
  logic        dec_reads_rs1;
  logic        dec_reads_rs2;
  logic        dec_is_load;
  logic        dec_writes;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        hazard;

  assign in_rs1 = inInstr[19:15];
  assign in_rs2 = inInstr[24:20];
  assign in_rd  = inInstr[11:7];

  always_comb begin
    dec_state     = StIdle;
    dec_imm       = '0;
    dec_legal     = 1'b1;
    dec_reads_rs1 = 1'b0;
    dec_reads_rs2 = 1'b0;
    dec_is_load   = 1'b0;
    case (inInstr[6:0])
      7'b0110011: begin
        dec_state     = StRegWrite;
        dec_reads_rs1 = 1'b1;
        dec_reads_rs2 = 1'b1;
      end
      7'b0010011: begin
        dec_state     = StRegWrite;
        dec_imm       = {{20{inInstr[31]}}, inInstr[31:20]};
        dec_reads_rs1 = 1'b1;
      end
      7'b0000011: begin
        dec_state     = StMemReadRegWrite;
        dec_imm       = {{20{inInstr[31]}}, inInstr[31:20]};
        dec_reads_rs1 = 1'b1;
        dec_is_load   = 1'b1;
      end
      7'b0100011: begin
        dec_state     = StMemWrite;
        dec_imm       = {{20{inInstr[31]}}, inInstr[31:25], inInstr[11:7]};
        dec_reads_rs1 = 1'b1;
        dec_reads_rs2 = 1'b1;
      end
      7'b1100011: begin
        dec_state     = StPcSelectWrite;
        dec_imm       = {{19{inInstr[31]}}, inInstr[31], inInstr[7], inInstr[30:25],
                         inInstr[11:8], 1'b0};
        dec_reads_rs1 = 1'b1;
        dec_reads_rs2 = 1'b1;
      end
      7'b1101111: begin
        dec_state = StPcWrite;
        dec_imm   = {{11{inInstr[31]}}, inInstr[31], inInstr[19:12], inInstr[20],
                     inInstr[30:21], 1'b0};
      end
      7'b1100111: begin
        dec_state     = StPcWrite;
        dec_imm       = {{20{inInstr[31]}}, inInstr[31:20]};
        dec_reads_rs1 = 1'b1;
      end
      7'b0110111: begin
        dec_state = StLuiRegWrite;
        dec_imm   = {inInstr[31:12], 12'b0};
      end
      7'b0010111: begin
        dec_state = StRegWrite;
        dec_imm   = {inInstr[31:12], 12'b0};
      end
      default: dec_legal = 1'b0;
    endcase
  end

  assign dec_writes = (dec_state == StRegWrite) || (dec_state == StMemReadRegWrite) ||
                      (dec_state == StPcWrite)  || (dec_state == StLuiRegWrite);

  // hist1 (the instruction now in the output register) wins over hist2
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input hist_t h1, input hist_t h2);
    if (rs != 5'd0 && h1.writes && rs == h1.rd) begin
      return 2'b01;
    end else if (rs != 5'd0 && h2.writes && rs == h2.rd) begin
      return 2'b10;
    end
    return 2'b00;
  endfunction

  assign hazard = inValid && hist1_q.is_load && (hist1_q.rd != 5'd0) &&
                  ((dec_reads_rs1 && in_rs1 == hist1_q.rd) ||
                   (dec_reads_rs2 && in_rs2 == hist1_q.rd));

  assign inReady = !stallIn && !hazard && !flush;

  always_comb begin
    dec_bundle         = '0;
    dec_bundle.valid   = 1'b1;
    dec_bundle.state   = STATE_W'(dec_state);
    dec_bundle.func3   = inInstr[14:12];
    dec_bundle.func7b5 = inInstr[30];
    dec_bundle.imm     = DATA_W'(dec_imm);
    dec_bundle.rs1     = in_rs1;
    dec_bundle.rs2     = in_rs2;
    dec_bundle.rd      = in_rd;
    dec_bundle.pc      = inPc;
    dec_bundle.fwd_a   = fwd_sel(in_rs1, hist1_q, hist2_q);
    dec_bundle.fwd_b   = fwd_sel(in_rs2, hist1_q, hist2_q);
    dec_bundle.illegal = !dec_legal;
  end

  always_comb begin
    out_d   = out_q;
    hist1_d = hist1_q;
    hist2_d = hist2_q;
    if (flush) begin
      out_d   = '0;
      hist1_d = '0;
      hist2_d = '0;
    end else if (stallIn) begin
      // held bundle stays, but the illegal pulse must not repeat
      out_d.illegal = 1'b0;
    end else if (inValid && !hazard) begin
      out_d           = dec_bundle;
      hist2_d         = hist1_q;
      hist1_d.writes  = dec_writes;
      hist1_d.rd      = in_rd;
      hist1_d.is_load = dec_is_load;
    end else begin
      out_d   = '0;
      hist2_d = hist1_q;
      hist1_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else begin
      out_q   <= out_d;
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end

  assign outValid = out_q.valid;
  assign state    = out_q.state;
  assign func3    = out_q.func3;
  assign func7b5  = out_q.func7b5;
  assign imm      = out_q.imm;
  assign rs1      = out_q.rs1;
  assign rs2      = out_q.rs2;
  assign rd       = out_q.rd;
  assign pcOut    = out_q.pc;
  assign forwardA = out_q.fwd_a;
  assign forwardB = out_q.fwd_b;
  assign illegal  = out_q.illegal;

endmodule
